pl_io_walker: RTL and testbench
===============================

Name: pl_io_walker

Overview:
Parametrised board I/O walk-test generator for PL bring-up. A single clock domain drives N_OUT pins with a walking-one, walking-zero or all-toggle pattern. Steps come from a debounced push-button or from an internal auto-step timer, in a selectable direction. It sits directly between board pins (button, LEDs, header I/O) and is the standard pin-continuity test block for new boards.

Parameters:
N_OUT, 13, number of driven outputs (>=2); LEDs occupy the low bits, header I/O the bits above them.
DEBOUNCE_CYCLES, 1000000, clocks the synchronised key must hold a new level before it is accepted (>=1).
AUTO_PERIOD, 50000000, clocks between automatic steps in auto mode (>=2).
PW, $clog2(N_OUT), width of pos.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_n  input  1  raw push-button, active-low, asynchronous to clk, bouncy
mode  input  2  00 manual walk-one, 01 manual walk-zero, 10 auto walk-one, 11 manual all-toggle; quasi-static
dir  input  1  1 = pos increments, 0 = pos decrements
io_out  output  N_OUT  pattern driven to pins, registered
pos  output  PW  current walk position, registered
step_pulse  output  1  one-cycle strobe on every accepted step, registered

Behaviour:
- Reset (rst_n low, async assert, sync release via normal flops):
  - pos=0, tog=0, step_pulse=0, io_out=1 (bit0 only).
  - Debounced key state = released (1); debounce counter = 0; auto timer = 0; sync flops = 1.
- Input synchroniser: key_n passes through 2 flops before any use.
- Debounce:
  - Counter counts while the synchronised level differs from the debounced state; any sample equal to the debounced state clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 on a differing sample, the debounced state takes the new level and the counter clears.
  - Press event = debounced transition 1->0. Release produces no event.
- Step source:
  - mode 00/01/11: press event.
  - mode 10: timer expiry, or a press event. A press restarts the timer.
  - A press and a timer expiry in the same cycle give exactly one step.
- Auto timer:
  - Counts 0..AUTO_PERIOD-1 only in mode 10; expiry at AUTO_PERIOD-1, then wraps to 0.
  - Held at 0 in all other modes, so re-entering mode 10 waits a full period.
- Step (edge E): step_pulse=1 for the cycle after E. pos and tog update on E.
  - dir=1: pos = (pos==N_OUT-1) ? 0 : pos+1.
  - dir=0: pos = (pos==0) ? N_OUT-1 : pos-1.
  - tog inverts on every step, in all modes.
- io_out, registered every cycle from the next-state pos/tog and the current mode:
  - 00/10: one-hot at pos.
  - 01: inverted one-hot at pos.
  - 11: all bits = tog.
  - Step-to-pin latency: the pattern changes on the same edge as step_pulse rises.
  - A mode change alone updates io_out one cycle later; pos is kept.
- Press-to-step latency: 2 sync + DEBOUNCE_CYCLES clocks after key_n settles low.
- dir/mode changing in the same cycle as a step: the new values apply to that step.
- Reset mid-walk: all state returns to the reset values immediately; no step_pulse is emitted.

Test Plan:
(N_OUT=13, DEBOUNCE_CYCLES=4, AUTO_PERIOD=8)
1. Reset, then hold key_n low 10 cycles, mode=00, dir=1 -> exactly one step_pulse, 6 cycles after key_n falls; pos=1; io_out=13'h0002.
2. key_n bounce of 1,2,3-cycle lows separated by 1-cycle highs, then a final stable low -> one step_pulse only, after the final stable low; release gives none.
3. mode=00, dir=1, 13 presses from pos=0 -> pos sequence 1..12 then 0; io_out=13'h0001 after the 13th press. Then dir=0, one press -> pos=12, io_out=13'h1000.
4. mode=01, pos=3 -> io_out=13'h1FF7. Switch to mode 11 with tog=0 -> io_out=13'h0000 next cycle; one press -> 13'h1FFF.
5. mode=10, no key -> step_pulse every 8 cycles. A press landing on an expiry cycle -> a single pulse, and the next pulse 8 cycles later.
6. Assert rst_n low mid-debounce and mid-auto-period -> outputs at reset values within the same cycle; no stale step_pulse after release.

Source files
------------

// File: rtl/pl_io_walker.sv
`default_nettype none
// ============================================================================
//  Module   : pl_io_walker
//  Purpose  : Board I/O walk-test generator for PL bring-up. Drives N_OUT
//             pins with a walking-one, walking-zero or all-toggle pattern.
//             Steps come from a debounced push-button or an internal
//             auto-step timer, in a selectable direction.
//
//  Ports    :
//    clk         in   1      system clock
//    rst_n       in   1      asynchronous active-low reset
//    key_n       in   1      raw push-button, active-low, asynchronous, bouncy
//    mode        in   2      00 walk-one, 01 walk-zero, 10 auto walk-one,
//                            11 all-toggle (quasi-static)
//    dir         in   1      1 = pos increments, 0 = pos decrements
//    io_out      out  N_OUT  registered pin pattern (LEDs in low bits)
//    pos         out  PW     registered walk position
//    step_pulse  out  1      registered one-cycle strobe per accepted step
//
//  Revision : 1.0  initial release
// ============================================================================
module pl_io_walker #(
    parameter int N_OUT           = 13,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int PW              = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [N_OUT-1:0] io_out,
    output logic [PW-1:0]    pos,
    output logic             step_pulse
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TW = $clog2(AUTO_PERIOD);

    localparam logic [c_DW-1:0] c_DB_LAST  = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TMR_LAST = c_TW'(AUTO_PERIOD - 1);
    localparam logic [PW-1:0]   c_POS_LAST = PW'(N_OUT - 1);

    localparam logic [1:0] c_MODE_WALK1  = 2'b00;
    localparam logic [1:0] c_MODE_WALK0  = 2'b01;
    localparam logic [1:0] c_MODE_AUTO   = 2'b10;
    localparam logic [1:0] c_MODE_TOGGLE = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             key_meta_q;
    logic             key_sync_q;
    logic             key_db_q,  key_db_d;
    logic [c_DW-1:0]  db_cnt_q,  db_cnt_d;
    logic [c_TW-1:0]  tmr_q,     tmr_d;
    logic [PW-1:0]    pos_q,     pos_d;
    logic             tog_q,     tog_d;
    logic             step_q,    step_d;
    logic [N_OUT-1:0] io_q,      io_d;

    logic             w_key_diff;
    logic             w_db_accept;
    logic             w_press;
    logic             w_auto;
    logic             w_expire;
    logic             w_step;
    logic [N_OUT-1:0] w_onehot;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; idles high so reset looks like "released".
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive samples that disagree with the accepted
    // level; any agreeing sample restarts the count. The new level is
    // accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    // ------------------------------------------------------------------
    assign w_key_diff  = (key_sync_q != key_db_q);
    assign w_db_accept = w_key_diff && (db_cnt_q == c_DB_LAST);
    // Only the released->pressed transition is an event.
    assign w_press     = w_db_accept && !key_sync_q;

    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (w_key_diff) begin
            if (w_db_accept) begin
                key_db_d = key_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + c_DW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto-step timer. Parked at zero outside auto mode so that entering
    // auto mode always waits a full period; a press restarts the period.
    // A press coinciding with expiry collapses into a single step.
    // ------------------------------------------------------------------
    assign w_auto   = (mode == c_MODE_AUTO);
    assign w_expire = w_auto && (tmr_q == c_TMR_LAST);
    assign w_step   = w_press || w_expire;

    always_comb begin
        tmr_d = tmr_q + c_TW'(1);
        if (!w_auto || w_press || w_expire) begin
            tmr_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Walk position and toggle phase. dir is taken live, so a direction
    // change in the step cycle already applies to that step.
    // ------------------------------------------------------------------
    always_comb begin
        pos_d  = pos_q;
        tog_d  = tog_q;
        step_d = w_step;
        if (w_step) begin
            tog_d = ~tog_q;
            if (dir) begin
                pos_d = (pos_q == c_POS_LAST) ? '0 : pos_q + PW'(1);
            end else begin
                pos_d = (pos_q == '0) ? c_POS_LAST : pos_q - PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pin pattern is built from the next-state position/phase so the pins
    // change on the same edge that raises step_pulse.
    // ------------------------------------------------------------------
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_onehot[i] = (pos_d == PW'(i));
        end
    end

    always_comb begin
        io_d = w_onehot;
        case (mode)
            c_MODE_WALK1:  io_d = w_onehot;
            c_MODE_WALK0:  io_d = ~w_onehot;
            c_MODE_AUTO:   io_d = w_onehot;
            c_MODE_TOGGLE: io_d = {N_OUT{tog_d}};
            default:       io_d = w_onehot;
        endcase
    end

    // ------------------------------------------------------------------
    // Main state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_q <= 1'b1;
            db_cnt_q <= '0;
            tmr_q    <= '0;
            pos_q    <= '0;
            tog_q    <= 1'b0;
            step_q   <= 1'b0;
            io_q     <= N_OUT'(1);
        end else begin
            key_db_q <= key_db_d;
            db_cnt_q <= db_cnt_d;
            tmr_q    <= tmr_d;
            pos_q    <= pos_d;
            tog_q    <= tog_d;
            step_q   <= step_d;
            io_q     <= io_d;
        end
    end

    assign io_out     = io_q;
    assign pos        = pos_q;
    assign step_pulse = step_q;

endmodule
`default_nettype wire

// File: tb/tb_pl_io_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pl_io_walker
//  Purpose  : Self-checking bench for pl_io_walker (N_OUT=13, debounce 4,
//             auto period 8). Stimulus pushes expected step results into a
//             queue; a monitor pops and compares on every step_pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pl_io_walker;

    localparam int N  = 13;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_n = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          dir = 1'b1;
    logic [N-1:0]  io_out;
    logic [PW-1:0] pos;
    logic          step_pulse;

    pl_io_walker #(
        .N_OUT           (N),
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (8),
        .PW              (PW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .mode       (mode),
        .dir        (dir),
        .io_out     (io_out),
        .pos        (pos),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           p;
        logic [N-1:0] io;
        int           c;   // expected cycle of the pulse, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int p, input logic [N-1:0] io, input int c);
        exp_t e;
        e.p = p; e.io = io; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Press: key low for 10 cycles, then high for 10 cycles. Step lands
    // 2 sync + 4 debounce clocks after the falling edge.
    task automatic press(input int p, input logic [N-1:0] io);
        key_n = 1'b0;
        push(p, io, cyc + 6);
        repeat (10) tick();
        key_n = 1'b1;
        repeat (10) tick();
    endtask

    // Monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_step_pulse", 32'(step_pulse), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("step_pos", 32'(pos), 32'(e.p));
                chk("step_io", 32'(io_out), 32'(e.io));
                if (e.c >= 0) chk("step_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected end");
        $fatal(1);
    end

    initial begin
        int c;
        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_io", 32'(io_out), 32'h0001);
        chk("rst_step", 32'(step_pulse), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_io", 32'(io_out), 32'h0001);

        // ---------------- 1: single press ----------------
        press(1, 13'h0002);
        chk("t1_pos", 32'(pos), 32'd1);
        chk("t1_io", 32'(io_out), 32'h0002);

        // ---------------- 2: bounce ----------------
        key_n = 1'b0; tick();
        key_n = 1'b1; tick();
        key_n = 1'b0; repeat (2) tick();
        key_n = 1'b1; tick();
        key_n = 1'b0; repeat (3) tick();
        key_n = 1'b1; tick();
        chk("t2_no_step_yet", 32'(exp_q.size()), 32'd0);
        press(2, 13'h0004);
        chk("t2_pos", 32'(pos), 32'd2);

        // ---------------- 3: full walk up, one step down ----------------
        rst_n = 1'b0; repeat (2) tick();
        rst_n = 1'b1; tick();
        chk("t3_start_pos", 32'(pos), 32'd0);
        for (int k = 1; k <= 13; k++) begin
            press(k % 13, 13'(1 << (k % 13)));
        end
        chk("t3_wrap_io", 32'(io_out), 32'h0001);
        dir = 1'b0;
        press(12, 13'h1000);
        chk("t3_down_pos", 32'(pos), 32'd12);
        chk("t3_down_io", 32'(io_out), 32'h1000);

        // ---------------- 4: walk-zero and all-toggle ----------------
        dir = 1'b1;
        press(0, 13'h0001);
        press(1, 13'h0002);
        press(2, 13'h0004);
        press(3, 13'h0008);
        mode = 2'b01;
        tick();
        chk("t4_walk0_io", 32'(io_out), 32'h1FF7);
        chk("t4_walk0_pos", 32'(pos), 32'd3);
        mode = 2'b11;
        tick();
        chk("t4_toggle0_io", 32'(io_out), 32'h0000);
        press(4, 13'h1FFF);
        chk("t4_toggle1_io", 32'(io_out), 32'h1FFF);

        // ---------------- 5: auto mode ----------------
        c = cyc;
        mode = 2'b10;
        tick();
        chk("t5_auto_io", 32'(io_out), 32'h0010);
        push(5, 13'h0020, c + 8);
        push(6, 13'h0040, c + 16);
        push(7, 13'h0080, c + 24);
        wait_until(c + 26);
        key_n = 1'b0;                    // step lands on the c+32 expiry
        push(8, 13'h0100, c + 32);
        push(9, 13'h0200, c + 40);
        push(10, 13'h0400, c + 48);
        wait_until(c + 36);
        key_n = 1'b1;
        wait_until(c + 44);
        key_n = 1'b0;                    // off-expiry press restarts period
        push(11, 13'h0800, c + 50);
        push(12, 13'h1000, c + 58);
        wait_until(c + 54);
        key_n = 1'b1;
        wait_until(c + 62);
        mode = 2'b00;
        repeat (20) tick();
        chk("t5_pos", 32'(pos), 32'd12);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- 6: reset mid-debounce / mid-period ----------------
        mode = 2'b10;
        repeat (2) tick();
        key_n = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_pos", 32'(pos), 32'd0);
        chk("t6_async_io", 32'(io_out), 32'h0001);
        chk("t6_async_step", 32'(step_pulse), 32'd0);
        key_n = 1'b1;
        mode = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("t6_after_pos", 32'(pos), 32'd0);
        chk("t6_after_io", 32'(io_out), 32'h0001);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
